// File: rtl/abs_step_pkg.sv
// Shared types and constants for the absolute-step accounting engine.
package abs_step_pkg;

   localparam int unsigned CNT_W      = 32;
   localparam int unsigned SUB_W      = 16;
   localparam int unsigned TICK_W_DEF = 27;

   localparam logic [CNT_W-1:0] CNT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_CLR  = 2'd1,
      OP_INC  = 2'd2,
      OP_DEC  = 2'd3
   } op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after i_ptr.
module rr_arbiter #(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic [N-1:0] o_gnt_c,
   output logic         o_valid_c
);

   logic [N-1:0] w_rot;
   logic [W-1:0] w_idx;

   // Rotate so bit 0 is the requester at the pointer position.
   assign w_rot     = N'({i_req, i_req} >> i_ptr);
   assign o_valid_c = |i_req;

   always_comb begin
      o_gnt_c = '0;
      w_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) w_idx = W'((k + int'(i_ptr)) % int'(N));
      end
      if (|i_req) o_gnt_c[w_idx] = 1'b1;
   end

endmodule

// File: rtl/abs_step_sched.sv
// Per-channel absolute step counters sharing one read-modify-write datapath,
// with step increments, periodic decay and host clears arbitrated onto it.
module abs_step_sched
   import abs_step_pkg::*;
#(
   parameter int unsigned NCH    = 8,
   parameter int unsigned TICK_W = TICK_W_DEF,
   parameter int unsigned AW     = $clog2(NCH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [NCH-1:0]   step_in,
   input  logic [NCH-1:0]   clr_req,
   input  logic [SUB_W-1:0] sub_in,
   input  logic [CNT_W-1:0] limit_in,
   input  logic [AW-1:0]    rd_addr,
   output logic [CNT_W-1:0] rd_data,
   output logic [NCH-1:0]   trip,
   output logic [NCH-1:0]   motor_en,
   output logic [NCH-1:0]   ovf,
   output logic             busy
);

   logic [CNT_W-1:0]  r_cnt [NCH];
   logic [NCH-1:0]    r_step_h0, r_step_h1;
   logic [NCH-1:0]    r_clr_pend, r_inc_pend, r_dec_pend;
   logic [NCH-1:0]    r_moved, r_ovf, r_trip, r_motor_en;
   logic [TICK_W-1:0] r_presc;
   logic [AW-1:0]     r_rr_ptr;
   logic [CNT_W-1:0]  r_rd_data;
   logic              r_busy;

   logic [NCH-1:0]    w_edge, w_inc_gnt;
   logic              w_inc_vld, w_tick;
   logic [AW-1:0]     w_clr_idx, w_inc_idx, w_dec_idx, w_ch, w_ptr_n;
   op_e               w_op;
   logic [NCH-1:0]    w_svc_oh, w_clr_oh, w_inc_oh, w_dec_oh;
   logic [CNT_W-1:0]  w_cur, w_new, w_eff_sub, w_rd_mux;
   logic [NCH-1:0]    w_clr_pend_n, w_inc_pend_n, w_dec_pend_n;
   logic [NCH-1:0]    w_moved_n, w_ovf_n, w_trip_n, w_trip_set;

   assign w_edge = r_step_h0 & ~r_step_h1;
   assign w_tick = &r_presc;

   rr_arbiter #(
      .N (NCH),
      .W (AW)
   ) u_inc_arb (
      .i_req     (r_inc_pend),
      .i_ptr     (r_rr_ptr),
      .o_gnt_c   (w_inc_gnt),
      .o_valid_c (w_inc_vld)
   );

   // Lowest-index encoders for clears and decays, one-hot to index for the grant.
   always_comb begin
      w_clr_idx = '0;
      w_dec_idx = '0;
      w_inc_idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (r_clr_pend[i]) w_clr_idx = AW'(i);
         if (r_dec_pend[i]) w_dec_idx = AW'(i);
         if (w_inc_gnt[i])  w_inc_idx = AW'(i);
      end
   end

   always_comb begin
      w_op = OP_NONE;
      w_ch = '0;
      if (|r_clr_pend) begin
         w_op = OP_CLR;
         w_ch = w_clr_idx;
      end else if (w_inc_vld) begin
         w_op = OP_INC;
         w_ch = w_inc_idx;
      end else if (|r_dec_pend) begin
         w_op = OP_DEC;
         w_ch = w_dec_idx;
      end
   end

   assign w_svc_oh  = (w_op == OP_NONE) ? '0 : (NCH'(1) << w_ch);
   assign w_clr_oh  = (w_op == OP_CLR) ? w_svc_oh : '0;
   assign w_inc_oh  = (w_op == OP_INC) ? w_svc_oh : '0;
   assign w_dec_oh  = (w_op == OP_DEC) ? w_svc_oh : '0;
   assign w_ptr_n   = (w_ch == AW'(NCH - 1)) ? '0 : w_ch + AW'(1);
   assign w_cur     = r_cnt[w_ch];
   assign w_eff_sub = sub_in[SUB_W-1] ? '0 : CNT_W'(sub_in);

   always_comb begin
      w_new = w_cur;
      case (w_op)
         OP_CLR:  w_new = '0;
         OP_INC:  w_new = (w_cur == CNT_MAX) ? CNT_MAX : w_cur + CNT_W'(1);
         OP_DEC:  w_new = (w_cur > w_eff_sub) ? w_cur - w_eff_sub : '0;
         default: w_new = w_cur;
      endcase
   end

   // Fresh edges survive their own service cycle; only unserviced repeats overflow.
   always_comb begin
      w_clr_pend_n = (r_clr_pend & ~w_clr_oh) | clr_req;
      w_inc_pend_n = (r_inc_pend & ~(w_clr_oh | w_inc_oh)) | w_edge;
      w_dec_pend_n = (r_dec_pend & ~(w_clr_oh | w_dec_oh)) | (w_tick ? ~r_moved : '0);
      w_moved_n    = w_tick ? w_edge : (r_moved | w_edge);
      w_ovf_n      = (r_ovf & ~w_clr_oh)
                   | (w_edge & r_inc_pend & ~(w_clr_oh | w_inc_oh));
      w_trip_set   = ((w_op == OP_INC) && (limit_in != '0) && (w_new >= limit_in))
                   ? w_inc_oh : '0;
      w_trip_n     = (r_trip & ~w_clr_oh) | w_trip_set;
   end

   always_comb begin
      w_rd_mux = '0;
      for (int i = 0; i < NCH; i++) begin
         if (rd_addr == AW'(i)) w_rd_mux = r_cnt[i];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_step_h0  <= '0;
         r_step_h1  <= '0;
         r_clr_pend <= '0;
         r_inc_pend <= '0;
         r_dec_pend <= '0;
         r_moved    <= '0;
         r_ovf      <= '0;
         r_trip     <= '0;
         r_motor_en <= '1;
         r_presc    <= '0;
         r_rr_ptr   <= '0;
         r_rd_data  <= '0;
         r_busy     <= 1'b0;
         for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
      end else begin
         r_step_h0  <= step_in;
         r_step_h1  <= r_step_h0;
         r_clr_pend <= w_clr_pend_n;
         r_inc_pend <= w_inc_pend_n;
         r_dec_pend <= w_dec_pend_n;
         r_moved    <= w_moved_n;
         r_ovf      <= w_ovf_n;
         r_trip     <= w_trip_n;
         r_motor_en <= ~w_trip_n;
         r_presc    <= r_presc + TICK_W'(1);
         r_rd_data  <= w_rd_mux;
         r_busy     <= |(w_clr_pend_n | w_inc_pend_n | w_dec_pend_n);
         if (w_op == OP_INC) r_rr_ptr <= w_ptr_n;
         if (w_op != OP_NONE) r_cnt[w_ch] <= w_new;
      end
   end

   assign rd_data  = r_rd_data;
   assign trip     = r_trip;
   assign motor_en = r_motor_en;
   assign ovf      = r_ovf;
   assign busy     = r_busy;

endmodule

// File: doc/abs_step_sched.md
Name: abs_step_sched

Overview:
- Shared absolute-step accounting engine for NCH stepper tuner channels in the resonance-control FPGA.
- Holds one 32-bit absolute-step count per channel in a register array, updated by a single read-modify-write datapath.
- Arbitrates step-edge increments, periodic decay decrements and host clears onto that datapath.
- Raises a sticky per-channel trip that gates the stepper enable when a channel's count reaches the host limit.

Parameters:
- NCH, 8, number of tuner channels (2..16).
- TICK_W, 27, decay prescaler width; a decay tick occurs every 2^TICK_W clocks (about 1.07 s at 125 MHz).
- AW, 3, channel index width, equal to clog2(NCH).

Ports:
- clock  in  1  local bus clock, 125 MHz.
- reset  in  1  synchronous, active-high reset.
- step_in  in  NCH  per-channel step level; each rising edge is one step.
- clr_req  in  NCH  per-channel single-cycle clear pulse from the host.
- sub_in  in  16  decay amount per tick; bit15=1 means zero decay.
- limit_in  in  32  trip threshold; 0 disables tripping.
- rd_addr  in  AW  host read index.
- rd_data  out  32  count of channel rd_addr, registered.
- trip  out  NCH  sticky trip flags.
- motor_en  out  NCH  per-channel enable, equal to ~trip.
- ovf  out  NCH  sticky flag: a step edge was lost.
- busy  out  1  high when any clear, increment or decay is pending.

Behaviour:
- Reset:
  - All counts, trip, ovf, pending bits, moved bits, prescaler, RR pointer and rd_data are cleared to 0.
  - motor_en resets to all 1s.
- Edge detection:
  - Each step_in bit passes through a 2-flop history; pattern 01 is an edge.
  - An edge sets inc_pend[ch] and moved[ch].
  - If inc_pend[ch] is already set and is not being serviced that cycle, set ovf[ch].
- Prescaler:
  - Free-running TICK_W-bit counter; tick is asserted when the counter is all 1s.
  - On tick, dec_pend[ch] is set for every channel with moved[ch]=0, and all moved bits are cleared.
  - A channel that stepped during the interval is not decayed for that interval.
- Service, at most one operation per cycle, in this priority:
  1. Clear: the lowest-index clr_pend channel. Writes count=0, clears trip, ovf, inc_pend and dec_pend for that channel, clears clr_pend.
  2. Increment: round-robin among inc_pend channels. The pointer advances to granted+1 (mod NCH). Writes count+1, saturating at 0xFFFFFFFF.
  3. Decrement: the lowest-index dec_pend channel. Writes max(count - eff_sub, 0), where eff_sub = sub_in[15] ? 0 : sub_in. Unsigned compare, no wrap below 0.
- clr_req pulses set clr_pend[ch].
- Simultaneous events:
  - A new edge on the same cycle as that channel's clear or increment service is kept as a fresh inc_pend; it does not set ovf.
  - A tick on the same cycle as a decrement service re-sets dec_pend for the channel if moved=0.
- Trip:
  - After any increment write, if limit_in != 0 and new count >= limit_in, set trip[ch] on the next cycle.
  - Trip is sticky; only a clear resets it.
  - Decrements never clear trip.
  - A limit change does not re-evaluate stored counts.
- Latency:
  - Edge to count update: 3 to NCH+2 cycles (2 sync cycles, plus arbitration, plus 1 write).
  - Read: rd_data is valid 1 cycle after rd_addr. A read on the write cycle returns the old value.
- busy = |(clr_pend | inc_pend | dec_pend).
- reset asserted mid-operation discards all pending work.

Decomposition:
- Package abs_step_pkg:
  - Op encoding enum: OP_NONE, OP_CLR, OP_INC, OP_DEC.
  - CNT_MAX = 32'hFFFFFFFF.
  - Default TICK_W.
- Sub-module rr_arbiter (parameter N): takes a request vector and pointer; returns a one-hot grant and a valid flag. Used for increment arbitration.
- Lowest-index priority encoders stay inline.

Test Plan:
- Reset, then one rising edge on step_in[3] -> count[3]=1 within 3 cycles; trip=0; motor_en=all 1s.
- All 8 channels edge in the same cycle, pointer=0 -> counts become 1 in order ch0..ch7 over 8 consecutive write cycles; busy drops afterwards.
- TICK_W=4, sub_in=5:
  - Channel 2 holds 12 and is idle -> after 1 tick, 7; after 2 ticks, 2; after 3 ticks, 0 (floor).
  - With sub_in=16'h8005 -> count stays unchanged.
- limit_in=3, four edges on ch5 -> trip[5] and motor_en[5]=0 after the 3rd write; count reaches 4.
- Continuing from the trip case: clr_req[5] pulse -> count 0, trip[5]=0, ovf[5]=0.
- Two edges on ch1 while inc_pend[1] is blocked by continuous clears on ch0 -> ovf[1]=1 and count[1] increments only once.
- An edge on ch4 within the tick interval -> ch4 is not decremented on that tick, while ch6 (idle) is decremented.
